// File: rtl/ucie_ctl_phy_sb_cfg_bridge.sv
// PHY-side bridge between the RDI config channel and the sideband link.
// It has a credited TX FIFO toward the sideband, a credit-gated RX FIFO toward the adapter, sticky error flags and level reporting.
module ucie_ctl_phy_sb_cfg_bridge #(
  parameter int unsigned NC         = 32,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned RX_DEPTH   = 4,
  parameter int unsigned RX_CRD_MAX = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_rdi_lp_cfg_valid,
  input  logic [NC-1:0]                   i_rdi_lp_cfg,
  output logic                            o_rdi_pl_cfg_crd,
  output logic                            o_sb_data_valid,
  output logic [NC-1:0]                   o_data_sent_sb,
  input  logic                            i_sb_tx_ready,
  input  logic                            i_sb_data_valid,
  input  logic [NC-1:0]                   i_data_received_sb,
  input  logic                            i_rdi_lp_cfg_crd,
  output logic                            o_rdi_pl_cfg_vld,
  output logic [NC-1:0]                   o_rdi_pl_cfg,
  input  logic                            i_err_clr,
  output logic                            o_err_tx_ovf,
  output logic                            o_err_rx_ovf,
  output logic                            o_err_crd_ovf,
  output logic [$clog2(TX_DEPTH+1)-1:0]   o_tx_level,
  output logic [$clog2(RX_DEPTH+1)-1:0]   o_rx_level
);

  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned TLW = $clog2(TX_DEPTH + 1);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned RLW = $clog2(RX_DEPTH + 1);
  localparam int unsigned CW  = $clog2(RX_CRD_MAX + 1);

  logic [NC-1:0]  tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TLW-1:0] tx_cnt;
  logic [TLW-1:0] tx_pend;
  logic [TLW:0]   tx_avail_c;
  logic           tx_full_c, tx_pop_c, tx_push_c;

  logic [NC-1:0]  rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RLW-1:0] rx_cnt;
  logic [CW-1:0]  rx_crd;
  logic           rx_full_c, rx_push_c, rx_dlv_c, crd_at_max_c;
  logic           tx_ovf_set_c, rx_ovf_set_c, crd_ovf_set_c;

  // A pop frees its slot in the same cycle, so a push into a full FIFO is accepted when a pop happens alongside it.
  assign tx_full_c  = (tx_cnt == TLW'(TX_DEPTH));
  assign tx_pop_c   = (tx_cnt != '0) && i_sb_tx_ready;
  assign tx_push_c  = i_rdi_lp_cfg_valid && (!tx_full_c || tx_pop_c);
  assign tx_avail_c = {1'b0, tx_pend} + (TLW+1)'(tx_pop_c);

  assign rx_full_c    = (rx_cnt == RLW'(RX_DEPTH));
  assign rx_push_c    = i_sb_data_valid && !rx_full_c;
  assign rx_dlv_c     = (rx_cnt != '0) && (rx_crd != '0);
  assign crd_at_max_c = (rx_crd == CW'(RX_CRD_MAX));

  assign tx_ovf_set_c  = i_rdi_lp_cfg_valid && tx_full_c && !tx_pop_c;
  assign rx_ovf_set_c  = i_sb_data_valid && rx_full_c;
  assign crd_ovf_set_c = i_rdi_lp_cfg_crd && !rx_dlv_c && crd_at_max_c;

  assign o_sb_data_valid = (tx_cnt != '0);
  assign o_data_sent_sb  = tx_mem[tx_rp];
  assign o_tx_level      = tx_cnt;
  assign o_rx_level      = rx_cnt;

  // TX FIFO toward the sideband
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      for (int i = 0; i < int'(TX_DEPTH); i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push_c) begin
        tx_mem[tx_wp] <= i_rdi_lp_cfg;
        tx_wp         <= tx_wp + TAW'(1);
      end
      if (tx_pop_c) tx_rp <= tx_rp + TAW'(1);
      tx_cnt <= tx_cnt + TLW'(tx_push_c) - TLW'(tx_pop_c);
    end
  end

  // Credit return: a freed slot becomes a pulse on the next cycle, one pulse per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_pend          <= TLW'(TX_DEPTH);
      o_rdi_pl_cfg_crd <= 1'b0;
    end else begin
      o_rdi_pl_cfg_crd <= (tx_avail_c != '0);
      tx_pend          <= (tx_avail_c == '0) ? '0 : TLW'(tx_avail_c - (TLW+1)'(1));
    end
  end

  // RX FIFO from the sideband, drained only against adapter credits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wp            <= '0;
      rx_rp            <= '0;
      rx_cnt           <= '0;
      rx_crd           <= '0;
      o_rdi_pl_cfg_vld <= 1'b0;
      o_rdi_pl_cfg     <= '0;
      for (int i = 0; i < int'(RX_DEPTH); i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push_c) begin
        rx_mem[rx_wp] <= i_data_received_sb;
        rx_wp         <= rx_wp + RAW'(1);
      end
      if (rx_dlv_c) begin
        rx_rp        <= rx_rp + RAW'(1);
        o_rdi_pl_cfg <= rx_mem[rx_rp];
      end
      o_rdi_pl_cfg_vld <= rx_dlv_c;
      rx_cnt <= rx_cnt + RLW'(rx_push_c) - RLW'(rx_dlv_c);
      if (i_rdi_lp_cfg_crd && !rx_dlv_c && !crd_at_max_c) rx_crd <= rx_crd + CW'(1);
      else if (rx_dlv_c && !i_rdi_lp_cfg_crd)             rx_crd <= rx_crd - CW'(1);
    end
  end

  // Sticky errors; a new event wins over a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_tx_ovf  <= 1'b0;
      o_err_rx_ovf  <= 1'b0;
      o_err_crd_ovf <= 1'b0;
    end else begin
      o_err_tx_ovf  <= tx_ovf_set_c  || (o_err_tx_ovf  && !i_err_clr);
      o_err_rx_ovf  <= rx_ovf_set_c  || (o_err_rx_ovf  && !i_err_clr);
      o_err_crd_ovf <= crd_ovf_set_c || (o_err_crd_ovf && !i_err_clr);
    end
  end

endmodule

// File: tb/tb_ucie_ctl_phy_sb_cfg_bridge.sv
// Scoreboard bench for ucie_ctl_phy_sb_cfg_bridge: a queue-based reference model predicts words, credits, levels and flags.
// A negedge monitor compares the DUT against those predictions.
module tb_ucie_ctl_phy_sb_cfg_bridge;
  localparam int unsigned NC   = 32;
  localparam int unsigned TXD  = 4;
  localparam int unsigned RXD  = 4;
  localparam int unsigned CMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, lp_vld, sb_rdy, sb_vld, crd_in, err_clr;
  logic [NC-1:0] lp_cfg, sb_data;
  logic          pl_crd, tx_vld, pl_vld, e_tx, e_rx, e_crd;
  logic [NC-1:0] tx_data, pl_cfg;
  logic [2:0]    tx_lvl, rx_lvl;

  ucie_ctl_phy_sb_cfg_bridge #(.NC(NC), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_CRD_MAX(CMAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rdi_lp_cfg_valid(lp_vld), .i_rdi_lp_cfg(lp_cfg), .o_rdi_pl_cfg_crd(pl_crd),
    .o_sb_data_valid(tx_vld), .o_data_sent_sb(tx_data), .i_sb_tx_ready(sb_rdy),
    .i_sb_data_valid(sb_vld), .i_data_received_sb(sb_data), .i_rdi_lp_cfg_crd(crd_in),
    .o_rdi_pl_cfg_vld(pl_vld), .o_rdi_pl_cfg(pl_cfg), .i_err_clr(err_clr),
    .o_err_tx_ovf(e_tx), .o_err_rx_ovf(e_rx), .o_err_crd_ovf(e_crd),
    .o_tx_level(tx_lvl), .o_rx_level(rx_lvl));

  int n_vec = 0, n_err = 0;

  // Reference model state: contents of each FIFO, credits owed, adapter credits held
  logic [NC-1:0] tx_q[$], rx_q[$], tx_exp[$], rx_exp[$];
  int            owed, rx_crd;
  bit            x_crd, x_txv, x_rxv, x_etx, x_erx, x_ecrd, mon_en;
  int            x_txl, x_rxl;
  logic [NC-1:0] x_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs sampled at the edge just passed
  task automatic model_update();
    bit pop, dlv, rfull, t_set, r_set, c_set;
    logic [NC-1:0] w;
    if (rst) begin
      tx_q.delete(); rx_q.delete(); tx_exp.delete(); rx_exp.delete();
      owed = TXD; rx_crd = 0; x_crd = 0; x_rxv = 0;
      x_etx = 0; x_erx = 0; x_ecrd = 0; x_hold = '0;
    end else begin
      pop = (tx_q.size() > 0) && sb_rdy;
      if (pop) void'(tx_q.pop_front());
      t_set = 0;
      if (lp_vld) begin
        if (tx_q.size() < TXD) begin
          tx_q.push_back(lp_cfg);
          tx_exp.push_back(lp_cfg);
        end else t_set = 1;
      end
      if (pop) owed++;
      x_crd = (owed > 0);
      if (x_crd) owed--;

      rfull = (rx_q.size() == RXD);
      dlv   = (rx_q.size() > 0) && (rx_crd > 0);
      if (dlv) begin
        w = rx_q.pop_front();
        rx_exp.push_back(w);
        x_hold = w;
      end
      r_set = sb_vld && rfull;
      if (sb_vld && !rfull) rx_q.push_back(sb_data);
      c_set = 0;
      if (crd_in && !dlv) begin
        if (rx_crd == CMAX) c_set = 1;
        else rx_crd++;
      end else if (dlv && !crd_in) rx_crd--;
      x_rxv  = dlv;
      x_etx  = t_set || (x_etx  && !err_clr);
      x_erx  = r_set || (x_erx  && !err_clr);
      x_ecrd = c_set || (x_ecrd && !err_clr);
    end
    x_txv  = (tx_q.size() > 0);
    x_txl  = tx_q.size();
    x_rxl  = rx_q.size();
    mon_en = 1;
  endtask

  // Monitor: mid-cycle compare of every output; word queues popped when the DUT presents a word
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pl_cfg_crd", 64'(pl_crd), 64'(x_crd));
      chk("sb_valid",   64'(tx_vld), 64'(x_txv));
      chk("pl_cfg_vld", 64'(pl_vld), 64'(x_rxv));
      chk("tx_level",   64'(tx_lvl), 64'(x_txl));
      chk("rx_level",   64'(rx_lvl), 64'(x_rxl));
      chk("err_tx_ovf", 64'(e_tx),   64'(x_etx));
      chk("err_rx_ovf", 64'(e_rx),   64'(x_erx));
      chk("err_crd_ovf",64'(e_crd),  64'(x_ecrd));
      if (tx_vld === 1'b1) begin
        chk("tx_word_expected", 64'(tx_exp.size() > 0), 64'd1);
        if (tx_exp.size() > 0) begin
          chk("tx_data", 64'(tx_data), 64'(tx_exp[0]));
          if (sb_rdy) void'(tx_exp.pop_front());
        end
      end
      if (pl_vld === 1'b1) begin
        chk("rx_word_expected", 64'(rx_exp.size() > 0), 64'd1);
        if (rx_exp.size() > 0) chk("rx_data", 64'(pl_cfg), 64'(rx_exp.pop_front()));
      end else begin
        chk("rx_data_hold", 64'(pl_cfg), 64'(x_hold));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    model_update();
  endtask

  task automatic cyc(input bit lv, input logic [NC-1:0] d, input bit rdy, input bit sv,
                     input logic [NC-1:0] sd, input bit ci, input bit clr);
    lp_vld = lv; lp_cfg = d; sb_rdy = rdy; sb_vld = sv; sb_data = sd; crd_in = ci; err_clr = clr;
    tick();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, '0, rdy, 0, '0, 0, 0);
  endtask

  initial begin
    int pulses;
    rst = 1; mon_en = 0;
    lp_vld = 0; lp_cfg = '0; sb_rdy = 0; sb_vld = 0; sb_data = '0; crd_in = 0; err_clr = 0;
    idle(3, 0);
    rst = 0;

    // Reset release: exactly TXD credit pulses
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1, 0);
      pulses += int'(pl_crd);
    end
    chk("reset_credit_pulses", 64'(pulses), 64'(TXD));

    // Two words held under backpressure, then drained
    cyc(1, 32'hA5A5_0001, 0, 0, '0, 0, 0);
    cyc(1, 32'hA5A5_0002, 0, 0, '0, 0, 0);
    idle(1, 0);
    idle(5, 1);

    // Overflow the TX FIFO, clear the flag, drain
    for (int i = 0; i < 5; i++) cyc(1, 32'hB000_0000 + 32'(i), 0, 0, '0, 0, 0);
    idle(2, 0);
    cyc(0, '0, 0, 0, '0, 0, 1);
    idle(6, 1);

    // RX words wait for adapter credits
    cyc(0, '0, 0, 1, 32'h11, 0, 0);
    cyc(0, '0, 0, 1, 32'h22, 0, 0);
    cyc(0, '0, 0, 1, 32'h33, 0, 0);
    idle(3, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    idle(4, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    idle(3, 0);

    // Credit arriving in the delivering cycle with one credit held
    cyc(0, '0, 0, 1, 32'h44, 0, 0);
    cyc(0, '0, 0, 1, 32'h55, 0, 0);
    idle(2, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    cyc(0, '0, 0, 0, '0, 1, 0);
    idle(3, 0);

    // Credit counter saturation, then clear
    for (int i = 0; i < int'(CMAX) + 1; i++) cyc(0, '0, 0, 0, '0, 1, 0);
    idle(2, 0);
    cyc(0, '0, 0, 0, '0, 0, 1);
    idle(6, 0);

    // Reset with both FIFOs partly full
    cyc(1, 32'hC1, 0, 0, '0, 0, 0);
    cyc(1, 32'hC2, 0, 0, '0, 0, 0);
    rst = 1;
    idle(1, 0);
    rst = 0;
    cyc(0, '0, 0, 1, 32'hD1, 0, 0);
    cyc(0, '0, 0, 1, 32'hD2, 0, 0);
    rst = 1;
    idle(1, 0);
    rst = 0;
    idle(8, 0);

    // Randomised traffic with occasional clears and resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(599) == 0) rst = 1;
      cyc(bit'($urandom_range(99) < 50), $urandom, bit'($urandom_range(99) < 60),
          bit'($urandom_range(99) < 40), $urandom, bit'($urandom_range(99) < 35),
          bit'($urandom_range(99) < 4));
      rst = 0;
    end

    // Drain both paths
    for (int i = 0; i < 20; i++) cyc(0, '0, 1, 0, '0, bit'(i < 6), 0);
    chk("tx_drained", 64'(tx_exp.size()), 64'd0);
    chk("rx_drained", 64'(rx_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ucie_ctl_phy_sb_cfg_bridge.md
Name: ucie_ctl_phy_sb_cfg_bridge

Overview:
Parametrised successor to the PHY sideband message interface. It bridges the RDI config channel (lp_cfg/pl_cfg) and the sideband link, with a buffered TX FIFO, credit return to the adapter, and a credit-gated RX FIFO. Also adds sideband backpressure, sticky error flags and fill-level reporting. Sits in the PHY between the RDI and the sideband serializer.

Parameters:
NC, 32, config/sideband word width in bits
TX_DEPTH, 4, TX FIFO depth in words; also the number of credits advertised to the adapter (power of 2, >=2)
RX_DEPTH, 4, RX FIFO depth in words (power of 2, >=2)
RX_CRD_MAX, 8, maximum adapter credits held by the RX credit counter

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_rdi_lp_cfg_valid  in  1  adapter config word valid (single-cycle per word)
i_rdi_lp_cfg  in  NC  adapter config word
o_rdi_pl_cfg_crd  out  1  credit return to the adapter, one pulse per credit
o_sb_data_valid  out  1  TX word valid toward the sideband
o_data_sent_sb  out  NC  TX word toward the sideband
i_sb_tx_ready  in  1  sideband accepts the TX word
i_sb_data_valid  in  1  RX word valid from the sideband
i_data_received_sb  in  NC  RX word from the sideband
i_rdi_lp_cfg_crd  in  1  adapter grants one RX credit
o_rdi_pl_cfg_vld  out  1  RX word valid to the adapter (single-cycle pulse)
o_rdi_pl_cfg  out  NC  RX word to the adapter
i_err_clr  in  1  clears all sticky error flags
o_err_tx_ovf  out  1  sticky: write while the TX FIFO is full
o_err_rx_ovf  out  1  sticky: sideband word while the RX FIFO is full
o_err_crd_ovf  out  1  sticky: adapter credit while the counter is at RX_CRD_MAX
o_tx_level  out  $clog2(TX_DEPTH+1)  TX FIFO occupancy
o_rx_level  out  $clog2(RX_DEPTH+1)  RX FIFO occupancy

Behaviour:
- Reset (i_rst=1 at an edge):
  - All outputs go to 0, both FIFOs are emptied and the RX credit counter is 0.
  - The TX pending-credit counter tx_pend is loaded with TX_DEPTH.
  - A reset mid-operation discards all buffered words and any in-flight credits.
- TX write: i_rdi_lp_cfg_valid and not full → word pushed, visible in o_tx_level next cycle. If full → word dropped, o_err_tx_ovf set next cycle.
- TX output: o_sb_data_valid/o_data_sent_sb come from the FIFO head. Minimum latency is 1 cycle (write in cycle N → valid in N+1).
  - Valid and data are held stable until i_sb_tx_ready.
  - Pop on valid && ready. Back-to-back pops give one word per cycle.
- Simultaneous TX push and pop when full: the push is accepted, because the pop frees the slot in the same cycle.
- TX credits:
  - o_rdi_pl_cfg_crd is 1 in a cycle iff tx_pend>0. Each such cycle decrements tx_pend.
  - Each pop increments tx_pend.
  - Simultaneous increment and decrement leaves tx_pend unchanged.
  - After reset: TX_DEPTH consecutive credit pulses starting the first cycle after reset deasserts.
  - A pop adds one pulse; the earliest pulse is the cycle after the pop.
- RX write: i_sb_data_valid and not full → word pushed. If full → word dropped, o_err_rx_ovf set next cycle. The sideband has no backpressure.
- RX credit counter rx_crd:
  - +1 per i_rdi_lp_cfg_crd, −1 per delivered word.
  - Credit and delivery in the same cycle net to 0.
  - A credit arriving at RX_CRD_MAX without a simultaneous delivery is dropped: rx_crd saturates and o_err_crd_ovf is set next cycle.
- RX delivery: when the RX FIFO is non-empty and rx_crd>0 → pop.
  - o_rdi_pl_cfg_vld pulses next cycle with the popped word on o_rdi_pl_cfg.
  - o_rdi_pl_cfg holds its last value when vld=0.
  - Minimum latency from i_sb_data_valid to o_rdi_pl_cfg_vld is 2 cycles, and 1 word per cycle is sustained while credits last.
- Errors:
  - Flags are sticky until i_err_clr.
  - If i_err_clr and a new error event occur in the same cycle, the set wins.
  - An error never blocks datapath operation.
- Ordering: words are strictly FIFO on both paths. The two paths are fully independent.

Test Plan:
- Reset release with TX_DEPTH=4 → o_rdi_pl_cfg_crd high for exactly 4 consecutive cycles, then 0; all other outputs are 0.
- Write 0xA5A5_0001, 0xA5A5_0002 with i_sb_tx_ready held 0 for 3 cycles, then 1:
  - o_data_sent_sb holds 0xA5A5_0001 stable, then advances to 0x…0002.
  - Exactly 2 credit pulses follow, each 1 cycle after its pop.
- Write 5 words with ready=0 (TX_DEPTH=4) → o_tx_level=4, o_err_tx_ovf=1, the 5th word is never emitted; i_err_clr → flag 0.
- 3 sideband words 0x11, 0x22, 0x33 with no adapter credits:
  - o_rdi_pl_cfg_vld stays 0 and o_rx_level=3.
  - Then grant 2 credits → 0x11, 0x22 delivered; 0x33 stays until a 3rd credit.
- Credit and delivery in the same cycle with rx_crd=1 and 2 words queued → both words delivered on consecutive cycles.
- RX_CRD_MAX+1 credits with an empty FIFO → rx_crd saturates at 8, o_err_crd_ovf=1.
- Assert i_rst with both FIFOs half full → both levels are 0 and no valid outputs next cycle; 4 fresh credit pulses follow.
